// File: rtl/game_tick_scheduler.sv
// Frame-locked game tick generator with run/pause/over FSM and PicoBlaze interrupt; tick 1 clk after vsync fall.
// No backpressure: interrupt is held until acked, ticks landing on a pending interrupt are counted as overruns.
module game_tick_scheduler #(
   parameter int SPEED_W = 4,
   parameter int TIME_W  = 16,
   parameter int MISS_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vert_sync,
   input  logic               start,
   input  logic               pause,
   input  logic               collision,
   input  logic [SPEED_W-1:0] speed,
   input  logic               interrupt_ack,
   output logic               game_tick,
   output logic               interrupt,
   output logic [1:0]         game_state,
   output logic [TIME_W-1:0]  game_time,
   output logic [MISS_W-1:0]  missed_ticks,
   output logic               overrun
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_PAUSED = 2'b10,
      ST_OVER   = 2'b11
   } state_t;

   localparam int PER_W = SPEED_W + 1;
   localparam logic [PER_W-1:0] PERIOD_MAX = {1'b1, {SPEED_W{1'b0}}};

   state_t              state_q, state_d;
   logic                vs_q, vs_d;
   logic                start_q, start_d;
   logic                pause_q, pause_d;
   logic [SPEED_W-1:0]  frame_div_q, frame_div_d;
   logic [PER_W-1:0]    period_q, period_d;
   logic                game_tick_q, game_tick_d;
   logic                interrupt_q, interrupt_d;
   logic [TIME_W-1:0]   game_time_q, game_time_d;
   logic [MISS_W-1:0]   missed_q, missed_d;
   logic                overrun_q, overrun_d;

   logic                frame_pulse, start_rise, pause_rise, tick, run_entry;
   logic [PER_W-1:0]    period_new;

   always_comb begin
      frame_pulse = vs_q & ~vert_sync;
      start_rise  = start & ~start_q;
      pause_rise  = pause & ~pause_q;
      period_new  = PERIOD_MAX - {1'b0, speed};
      // Tick is judged on the pre-transition state so a same-cycle pause/collision still ticks.
      tick = (state_q == ST_RUN) && frame_pulse &&
             ({1'b0, frame_div_q} == (period_q - PER_W'(1)));

      vs_d        = vert_sync;
      start_d     = start;
      pause_d     = pause;
      state_d     = state_q;
      run_entry   = 1'b0;
      frame_div_d = frame_div_q;
      period_d    = period_q;
      game_time_d = game_time_q;
      missed_d    = missed_q;
      overrun_d   = overrun_q;

      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start_rise) begin
               state_d   = ST_RUN;
               run_entry = 1'b1;
            end
         end
         ST_RUN: begin
            if (collision)       state_d = ST_OVER;
            else if (pause_rise) state_d = ST_PAUSED;
         end
         ST_PAUSED: begin
            if (collision)       state_d = ST_OVER;
            else if (pause_rise) state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase

      if (run_entry) begin
         frame_div_d = '0;
         game_time_d = '0;
         missed_d    = '0;
         overrun_d   = 1'b0;
         period_d    = period_new;
      end else if (tick) begin
         frame_div_d = '0;
         game_time_d = game_time_q + TIME_W'(1);
         period_d    = period_new;
      end else if (state_q == ST_RUN && frame_pulse) begin
         frame_div_d = frame_div_q + SPEED_W'(1);
      end

      // A tick coinciding with the ack replaces the old request rather than overrunning it.
      if (tick && interrupt_q && !interrupt_ack) begin
         overrun_d = 1'b1;
         if (missed_q != {MISS_W{1'b1}}) missed_d = missed_q + MISS_W'(1);
      end

      game_tick_d = tick;
      interrupt_d = tick | (interrupt_q & ~interrupt_ack);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         vs_q        <= 1'b1;
         start_q     <= 1'b0;
         pause_q     <= 1'b0;
         frame_div_q <= '0;
         period_q    <= '0;
         game_tick_q <= 1'b0;
         interrupt_q <= 1'b0;
         game_time_q <= '0;
         missed_q    <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         vs_q        <= vs_d;
         start_q     <= start_d;
         pause_q     <= pause_d;
         frame_div_q <= frame_div_d;
         period_q    <= period_d;
         game_tick_q <= game_tick_d;
         interrupt_q <= interrupt_d;
         game_time_q <= game_time_d;
         missed_q    <= missed_d;
         overrun_q   <= overrun_d;
      end
   end

   assign game_tick    = game_tick_q;
   assign interrupt    = interrupt_q;
   assign game_state   = state_q;
   assign game_time    = game_time_q;
   assign missed_ticks = missed_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: directed frames push expected ticks into a queue,
// a negedge monitor pops and compares whenever game_tick is seen.
module tb_game_tick_scheduler;

   logic       clk = 1'b0;
   logic       rst, vert_sync, start, pause, collision, interrupt_ack;
   logic [3:0] speed;
   logic       game_tick, interrupt, overrun;
   logic [1:0] game_state;
   logic [15:0] game_time;
   logic [7:0] missed_ticks;

   game_tick_scheduler #(.SPEED_W(4), .TIME_W(16), .MISS_W(8)) dut (
      .clk(clk), .rst(rst), .vert_sync(vert_sync), .start(start), .pause(pause),
      .collision(collision), .speed(speed), .interrupt_ack(interrupt_ack),
      .game_tick(game_tick), .interrupt(interrupt), .game_state(game_state),
      .game_time(game_time), .missed_ticks(missed_ticks), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int gt;
      int miss;
      int ovr;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Scoreboard monitor: every observed tick must match the oldest expectation.
   always @(negedge clk) begin
      if (game_tick) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_tick", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("tick_cycle", cyc, e.cyc);
            chk("tick_game_time", int'(game_time), e.gt);
            chk("tick_interrupt", int'(interrupt), 1);
            chk("tick_missed", int'(missed_ticks), e.miss);
            chk("tick_overrun", int'(overrun), e.ovr);
         end
      end
   end

   task automatic frame(input bit exp_tick, input int gt, input int miss, input int ovr,
                        input int len, input bit ack_edge, input bit ack_late);
      @(negedge clk);
      vert_sync     = 1'b0;
      interrupt_ack = ack_edge;
      if (exp_tick) exp_q.push_back('{cyc + 1, gt, miss, ovr});
      @(negedge clk);
      interrupt_ack = 1'b0;
      @(negedge clk);
      vert_sync = 1'b1;
      for (int i = 3; i < len; i++) begin
         @(negedge clk);
         interrupt_ack = ack_late && (i == 3);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic pulse_pause();
      @(negedge clk) pause = 1'b1;
      @(negedge clk) pause = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge clk) interrupt_ack = 1'b1;
      @(negedge clk) interrupt_ack = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_tick"}, int'(game_tick), 0);
      chk({tag, "_interrupt"}, int'(interrupt), 0);
      chk({tag, "_state"}, int'(game_state), 0);
      chk({tag, "_time"}, int'(game_time), 0);
      chk({tag, "_missed"}, int'(missed_ticks), 0);
      chk({tag, "_overrun"}, int'(overrun), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; vert_sync = 1'b1; start = 1'b0; pause = 1'b0;
      collision = 1'b0; interrupt_ack = 1'b0; speed = 4'd0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      // Period 1: every frame ticks, acked in the high phase.
      speed = 4'd15;
      pulse_start();
      chk("t1_state_run", int'(game_state), 1);
      frame(1, 1, 0, 0, 100, 0, 1);
      frame(1, 2, 0, 0, 100, 0, 1);
      speed = 4'd12;
      frame(1, 3, 0, 0, 100, 0, 1);
      chk("t1_int_cleared", int'(interrupt), 0);

      // Period 4 latched at the previous tick.
      for (int i = 1; i <= 12; i++) begin
         case (i)
            4:  frame(1, 4, 0, 0, 8, 0, 1);
            8:  frame(1, 5, 0, 0, 8, 0, 1);
            12: frame(1, 6, 0, 0, 8, 0, 1);
            default: frame(0, 0, 0, 0, 8, 0, 1);
         endcase
      end
      // Speed change after edge 5 waits for the edge-8 tick, then period 2.
      for (int i = 1; i <= 12; i++) begin
         case (i)
            4:  frame(1, 7, 0, 0, 8, 0, 1);
            8:  frame(1, 8, 0, 0, 8, 0, 1);
            10: frame(1, 9, 0, 0, 8, 0, 1);
            12: frame(1, 10, 0, 0, 8, 0, 1);
            default: frame(0, 0, 0, 0, 8, 0, 1);
         endcase
         if (i == 5) speed = 4'd14;
      end

      // Never ack: overruns accumulate and saturate.
      speed = 4'd15;
      frame(0, 0, 0, 0, 4, 0, 0);
      frame(1, 11, 0, 0, 4, 0, 0);
      for (int k = 1; k <= 10; k++) frame(1, 11 + k, k, 1, 4, 0, 0);
      frame(1, 22, 10, 1, 4, 1, 0);
      chk("t3_int_held_after_same_cycle_ack", int'(interrupt), 1);
      for (int k = 11; k <= 300; k++) frame(1, 12 + k, (k > 255) ? 255 : k, 1, 4, 0, 0);
      chk("t3_missed_saturated", int'(missed_ticks), 255);
      chk("t3_int_still_set", int'(interrupt), 1);
      pulse_ack();
      chk("t3_int_cleared", int'(interrupt), 0);
      speed = 4'd12;
      frame(1, 313, 255, 1, 8, 0, 1);

      // Pause mid-period: frames while paused are ignored.
      frame(0, 0, 0, 0, 8, 0, 0);
      frame(0, 0, 0, 0, 8, 0, 0);
      pulse_pause();
      chk("t4_state_paused", int'(game_state), 2);
      for (int i = 0; i < 10; i++) frame(0, 0, 0, 0, 8, 0, 0);
      pulse_pause();
      chk("t4_state_resumed", int'(game_state), 1);
      frame(0, 0, 0, 0, 8, 0, 0);
      frame(1, 314, 255, 1, 8, 0, 1);

      // Collision beats pause; restart clears counters.
      @(negedge clk);
      collision = 1'b1; pause = 1'b1;
      @(negedge clk);
      collision = 1'b0; pause = 1'b0;
      chk("t5_state_over", int'(game_state), 3);
      frame(0, 0, 0, 0, 8, 0, 0);
      pulse_start();
      chk("t5_state_run", int'(game_state), 1);
      chk("t5_time_clr", int'(game_time), 0);
      chk("t5_overrun_clr", int'(overrun), 0);
      chk("t5_missed_clr", int'(missed_ticks), 0);
      for (int i = 1; i <= 4; i++) frame(i == 4, 1, 0, 0, 8, 0, 0);
      frame(0, 0, 0, 0, 8, 0, 0);

      // Reset mid-interrupt and mid-period, with start held through reset.
      chk("t6_int_pending", int'(interrupt), 1);
      @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      chk_all_zero("t6_reset");
      rst = 1'b0;
      @(negedge clk);
      chk("t6_single_start_run", int'(game_state), 1);
      @(negedge clk) collision = 1'b1;
      @(negedge clk) collision = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_no_second_start", int'(game_state), 3);
      start = 1'b0;

      repeat (5) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
